// File: rtl/rf_rdport_arb_pkg.sv
// Shared defaults and helpers for the register-file read-port arbiter.
package rf_rdport_arb_pkg;

    localparam int DEF_DW        = 64;
    localparam int DEF_AW        = 5;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_NUM_PORT  = 2;
    localparam int DEF_NUM_WRITE = 2;

    // Circular index wrap; idx is never more than 2*n-1 at the call sites.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/rf_rr_pick.sv
// Rotating-priority multi-grant picker: grants up to NUM_PORT valid requesters
// scanning circularly from ptr, packing them onto ports 0..k-1 in scan order.
module rf_rr_pick
    import rf_rdport_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int NUM_PORT = DEF_NUM_PORT,
    parameter int IDW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]            valid,
    input  logic [IDW-1:0]                ptr,
    output logic [NUM_REQ-1:0]            req_gnt,
    output logic [NUM_PORT-1:0]           port_vld,
    output logic [NUM_PORT-1:0][IDW-1:0]  port_id,
    output logic [IDW-1:0]                next_ptr
);

    int cnt;
    int idx;
    int last;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path infers a latch.
        req_gnt  = '0;
        port_vld = '0;
        port_id  = '0;
        next_ptr = ptr;
        cnt      = 0;
        idx      = 0;
        last     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_wrap(int'(ptr) + i, NUM_REQ);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (r == idx && valid[r] && cnt < NUM_PORT) begin
                    req_gnt[r] = 1'b1;
                    for (int p = 0; p < NUM_PORT; p++) begin
                        if (p == cnt) begin
                            port_vld[p] = 1'b1;
                            port_id[p]  = IDW'(r);
                        end
                    end
                    cnt  = cnt + 1;
                    last = r;
                end
            end
        end
        // Next scan starts just past the last requester served.
        if (cnt != 0) next_ptr = IDW'(rr_wrap(last + 1, NUM_REQ));
    end

endmodule

// File: rtl/rf_rdport_arb.sv
// Shares NUM_PORT register-file read ports among NUM_REQ requesters, returning data one cycle later.
// Build define NCPU_RF_ARB_BYPASS_EN forwards same-cycle RF writes into the response.
module rf_rdport_arb
    import rf_rdport_arb_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int NUM_PORT  = DEF_NUM_PORT,
    parameter int NUM_WRITE = DEF_NUM_WRITE
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*AW-1:0]     i_req_addr,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [NUM_REQ*DW-1:0]     o_rsp_data,
    output logic [NUM_PORT-1:0]       o_rf_re,
    output logic [NUM_PORT*AW-1:0]    o_rf_raddr,
    input  logic [NUM_PORT*DW-1:0]    i_rf_rdata,
    input  logic [NUM_WRITE-1:0]      i_rf_we,
    input  logic [NUM_WRITE*AW-1:0]   i_rf_waddr,
    input  logic [NUM_WRITE*DW-1:0]   i_rf_wdata
);

    localparam int IDW = $clog2(NUM_REQ);

    logic [IDW-1:0]                rr_ptr;
    logic [IDW-1:0]                next_ptr;
    logic [NUM_REQ-1:0]            req_gnt;
    logic [NUM_PORT-1:0]           port_vld;
    logic [NUM_PORT-1:0][IDW-1:0]  port_id;
    logic [NUM_PORT-1:0]           tag_vld;
    logic [NUM_PORT-1:0][IDW-1:0]  tag_id;
    logic [NUM_PORT-1:0][DW-1:0]   port_data;

    rf_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .NUM_PORT (NUM_PORT),
        .IDW      (IDW)
    ) u_pick (
        .valid    (i_req_valid),
        .ptr      (rr_ptr),
        .req_gnt  (req_gnt),
        .port_vld (port_vld),
        .port_id  (port_id),
        .next_ptr (next_ptr)
    );

    assign o_req_ready = RST ? '0 : req_gnt;
    assign o_rf_re     = RST ? '0 : port_vld;

    always_comb begin
        o_rf_raddr = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (port_vld[p] && port_id[p] == IDW'(r))
                    o_rf_raddr[p*AW +: AW] = i_req_addr[r*AW +: AW];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr  <= '0;
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            rr_ptr  <= next_ptr;
            tag_vld <= port_vld;
            tag_id  <= port_id;
        end
    end

`ifdef NCPU_RF_ARB_BYPASS_EN
    logic [NUM_PORT-1:0]          byp_hit_d;
    logic [NUM_PORT-1:0]          byp_hit_q;
    logic [NUM_PORT-1:0][DW-1:0]  byp_data_d;
    logic [NUM_PORT-1:0][DW-1:0]  byp_data_q;

    // Ascending write index lets the highest-numbered hit win, matching RF write priority.
    always_comb begin
        byp_hit_d  = '0;
        byp_data_d = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (port_vld[p] && i_rf_we[w] &&
                    i_rf_waddr[w*AW +: AW] == o_rf_raddr[p*AW +: AW]) begin
                    byp_hit_d[p]  = 1'b1;
                    byp_data_d[p] = i_rf_wdata[w*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) byp_hit_q <= '0;
        else     byp_hit_q <= byp_hit_d;
    end

    // NOTE: captured write data is pure datapath qualified by byp_hit_q, so it needs no reset.
    always_ff @(posedge CLK) begin
        byp_data_q <= byp_data_d;
    end

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++)
            port_data[p] = byp_hit_q[p] ? byp_data_q[p] : i_rf_rdata[p*DW +: DW];
    end
`else
    logic unused_snoop;
    assign unused_snoop = ^{i_rf_we, i_rf_waddr, i_rf_wdata};

    always_comb begin
        for (int p = 0; p < NUM_PORT; p++)
            port_data[p] = i_rf_rdata[p*DW +: DW];
    end
`endif

    // Route each port's returning data to the requester recorded in its tag.
    always_comb begin
        o_rsp_valid = '0;
        o_rsp_data  = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (tag_vld[p] && tag_id[p] == IDW'(r)) begin
                    o_rsp_valid[r]          = 1'b1;
                    o_rsp_data[r*DW +: DW]  = port_data[p];
                end
            end
        end
    end

endmodule
